// File: rtl/param_clb.sv
// rtl/param_clb.sv - parametrised CLB slice array with serial shadow config and length-checked commit
module param_clb #(
  parameter int NUM_IN   = 4,
  parameter int LUT_K    = 4,
  parameter int NUM_LUTS = 2
) (
  input  logic                clb_clk,
  input  logic                reset,
  input  logic                cfg_en,
  input  logic                cfg_in,
  input  logic                cfg_commit,
  output logic                cfg_out,
  output logic                cfg_err,
  output logic                configured,
  input  logic [NUM_IN-1:0]   in,
  input  logic                ce,
  input  logic                sr,
  output logic [NUM_LUTS-1:0] out
);

  localparam int SEL_W       = $clog2(NUM_IN + NUM_LUTS);
  localparam int MASK_W      = 2 ** LUT_K;
  localparam int SLICE_W     = LUT_K * SEL_W + MASK_W + 5;
  localparam int CONFIG_SIZE = NUM_LUTS * SLICE_W;
  localparam int POOL_W      = 2 ** SEL_W;
  localparam int CNT_W       = $clog2(CONFIG_SIZE + 2);
  localparam int MASK_LSB    = LUT_K * SEL_W;
  localparam int FF_LSB      = MASK_LSB + MASK_W;
  localparam int OSEL_LSB    = FF_LSB + 3;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CONFIG_SIZE);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CONFIG_SIZE + 1);

  localparam logic [0:0] ST_UNCONFIG = 1'b0;
  localparam logic [0:0] ST_ACTIVE   = 1'b1;

  logic [CONFIG_SIZE-1:0] shadow_q, shadow_d;
  logic [CONFIG_SIZE-1:0] active_q, active_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [NUM_LUTS-1:0]    ff_q, ff_d;
  logic                   err_q, err_d;
  logic [0:0]             state_q, state_d;

  logic                   commit_ok;
  logic [POOL_W-1:0]      pool;
  logic [NUM_LUTS-1:0]    lut_out;
  logic [NUM_LUTS-1:0]    ce_en;
  logic [NUM_LUTS-1:0]    sr_en;
  logic [NUM_LUTS-1:0]    init_act;
  logic [NUM_LUTS-1:0]    init_new;
  logic [NUM_LUTS-1:0]    slice_out;

  assign commit_ok  = cfg_commit && (count_q == CNT_FULL);
  assign configured = (state_q == ST_ACTIVE);
  assign cfg_err    = err_q;
  assign cfg_out    = shadow_q[0];
  assign out        = configured ? slice_out : '0;

  // LUT input pool: external inputs, then registered slice outputs, unused codes read 0
  always_comb begin
    pool                     = '0;
    pool[NUM_IN-1:0]         = in;
    pool[NUM_IN +: NUM_LUTS] = ff_q;
  end

  for (genvar i = 0; i < NUM_LUTS; i++) begin : g_slice
    logic [SLICE_W-1:0] field;
    logic [MASK_W-1:0]  mask;
    logic [1:0]         osel;
    logic [LUT_K-1:0]   lut_idx;
    logic               mux_out;

    assign field       = active_q[i*SLICE_W +: SLICE_W];
    assign mask        = field[MASK_LSB +: MASK_W];
    assign osel        = field[OSEL_LSB +: 2];
    assign ce_en[i]    = field[FF_LSB];
    assign init_act[i] = field[FF_LSB+1];
    assign sr_en[i]    = field[FF_LSB+2];
    // init of the config about to be committed comes from the shadow, not the active copy
    assign init_new[i] = shadow_q[i*SLICE_W + FF_LSB + 1];
    assign lut_out[i]  = mask[lut_idx];
    assign slice_out[i] = mux_out;

    // gather the LUT address bits from the pool through the per-input selectors
    always_comb begin
      lut_idx = '0;
      for (int j = 0; j < LUT_K; j++) begin
        lut_idx[j] = pool[field[j*SEL_W +: SEL_W]];
      end
    end

    // slice output mux: LUT, FF, inverted LUT, or constant 0
    always_comb begin
      mux_out = 1'b0;
      case (osel)
        2'b00:   mux_out = lut_out[i];
        2'b01:   mux_out = ff_q[i];
        2'b10:   mux_out = ~lut_out[i];
        default: mux_out = 1'b0;
      endcase
    end
  end

  // config path: serial shift into shadow, commit wins over shift and checks the bit count
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    count_d  = count_q;
    err_d    = err_q;
    state_d  = state_q;
    if (cfg_commit) begin
      count_d = '0;
      if (count_q == CNT_FULL) begin
        active_d = shadow_q;
        err_d    = 1'b0;
        state_d  = ST_ACTIVE;
      end else begin
        err_d = 1'b1;
      end
    end else if (cfg_en) begin
      shadow_d = {cfg_in, shadow_q[CONFIG_SIZE-1:1]};
      if (count_q != CNT_SAT) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // slice FFs: load init on a valid commit, otherwise restore/enable/hold while active
  always_comb begin
    ff_d = ff_q;
    for (int i = 0; i < NUM_LUTS; i++) begin
      if (commit_ok) begin
        ff_d[i] = init_new[i];
      end else if ((state_q == ST_ACTIVE) && !cfg_commit) begin
        if (sr_en[i] && sr) begin
          ff_d[i] = init_act[i];
        end else if (!ce_en[i] || ce) begin
          ff_d[i] = lut_out[i];
        end
      end
    end
  end

  // state registers, cleared immediately by reset
  always_ff @(posedge clb_clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
      active_q <= '0;
      count_q  <= '0;
      ff_q     <= '0;
      err_q    <= 1'b0;
      state_q  <= ST_UNCONFIG;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      count_q  <= count_d;
      ff_q     <= ff_d;
      err_q    <= err_d;
      state_q  <= state_d;
    end
  end

endmodule

// File: tb/tb_param_clb.sv
// tb/tb_param_clb.sv - directed self-checking bench for param_clb at default parameters
module tb_param_clb;

  logic       clb_clk = 1'b0;
  logic       reset = 1'b0;
  logic       cfg_en = 1'b0;
  logic       cfg_in = 1'b0;
  logic       cfg_commit = 1'b0;
  logic       ce = 1'b0;
  logic       sr = 1'b0;
  logic [3:0] in = 4'h0;
  logic       cfg_out;
  logic       cfg_err;
  logic       configured;
  logic [1:0] out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [65:0] cfg2;
  logic [65:0] cfg4;

  param_clb #(.NUM_IN(4), .LUT_K(4), .NUM_LUTS(2)) dut (
    .clb_clk(clb_clk),
    .reset(reset),
    .cfg_en(cfg_en),
    .cfg_in(cfg_in),
    .cfg_commit(cfg_commit),
    .cfg_out(cfg_out),
    .cfg_err(cfg_err),
    .configured(configured),
    .in(in),
    .ce(ce),
    .sr(sr),
    .out(out)
  );

  always #5 clb_clk = ~clb_clk;

  function automatic logic [32:0] mk_slice(input int s0, input int s1, input int s2, input int s3,
                                           input logic [15:0] mask, input logic sr_en,
                                           input logic init, input logic ce_en, input logic [1:0] osel);
    logic [2:0] a, b, c, d;
    a = 3'(s0);
    b = 3'(s1);
    c = 3'(s2);
    d = 3'(s3);
    return {osel, sr_en, init, ce_en, mask, d, c, b, a};
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clb_clk);
    #1;
  endtask

  task automatic shift_vec(input logic [65:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      cfg_en = 1'b1;
      cfg_in = v[k % 66];
      tick();
    end
    cfg_en = 1'b0;
    cfg_in = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    cfg2 = {mk_slice(4, 5, 6, 7, 16'h0000, 1'b1, 1'b0, 1'b1, 2'b11),
            mk_slice(0, 1, 2, 3, 16'h8000, 1'b0, 1'b0, 1'b0, 2'b00)};
    cfg4 = {mk_slice(5, 0, 0, 0, 16'h5555, 1'b1, 1'b0, 1'b0, 2'b01),
            mk_slice(0, 1, 2, 3, 16'h8000, 1'b0, 1'b1, 1'b1, 2'b01)};

    // reset with no clock edge yet
    #1;
    reset = 1'b1;
    #1;
    check_eq("rst_out", 128'(out), 128'(2'b00));
    check_eq("rst_configured", 128'(configured), 128'(1'b0));
    check_eq("rst_cfg_err", 128'(cfg_err), 128'(1'b0));
    check_eq("rst_cfg_out", 128'(cfg_out), 128'(1'b0));
    tick();
    reset = 1'b0;

    // AND4 on slice 0
    shift_vec(cfg2, 66);
    check_eq("and_pre_commit_configured", 128'(configured), 128'(1'b0));
    commit();
    check_eq("and_configured", 128'(configured), 128'(1'b1));
    check_eq("and_cfg_err", 128'(cfg_err), 128'(1'b0));
    in = 4'hF;
    #1;
    check_eq("and_in_F", 128'(out), 128'(2'b01));
    in = 4'hE;
    #1;
    check_eq("and_in_E", 128'(out), 128'(2'b00));

    // bad-length commit while active keeps the old config
    in = 4'hF;
    commit();
    check_eq("active_bad_commit_err", 128'(cfg_err), 128'(1'b1));
    check_eq("active_bad_commit_configured", 128'(configured), 128'(1'b1));
    check_eq("active_bad_commit_out", 128'(out), 128'(2'b01));

    // readback of the shadow while the active config keeps running
    for (int k = 0; k < 66; k++) begin
      check_eq($sformatf("readback_bit%0d", k), 128'(cfg_out), 128'(cfg2[k]));
      check_eq($sformatf("readback_out%0d", k), 128'(out), 128'(2'b01));
      cfg_en = 1'b1;
      cfg_in = 1'b0;
      tick();
    end
    cfg_en = 1'b0;

    // shift and commit together: commit of the all-zero shadow, shift dropped
    cfg_en = 1'b1;
    cfg_in = 1'b1;
    cfg_commit = 1'b1;
    tick();
    cfg_en = 1'b0;
    cfg_in = 1'b0;
    cfg_commit = 1'b0;
    check_eq("both_configured", 128'(configured), 128'(1'b1));
    check_eq("both_cfg_err", 128'(cfg_err), 128'(1'b0));
    check_eq("both_out", 128'(out), 128'(2'b00));
    shift_vec(cfg2, 66);
    commit();
    check_eq("after_both_cfg_err", 128'(cfg_err), 128'(1'b0));
    check_eq("after_both_out", 128'(out), 128'(2'b01));

    // short and over-long shifts are rejected
    pulse_reset();
    shift_vec(cfg2, 65);
    commit();
    check_eq("short_cfg_err", 128'(cfg_err), 128'(1'b1));
    check_eq("short_configured", 128'(configured), 128'(1'b0));
    check_eq("short_out", 128'(out), 128'(2'b00));
    shift_vec(cfg2, 66);
    commit();
    check_eq("exact_cfg_err", 128'(cfg_err), 128'(1'b0));
    check_eq("exact_configured", 128'(configured), 128'(1'b1));
    shift_vec(cfg2, 70);
    commit();
    check_eq("long_cfg_err", 128'(cfg_err), 128'(1'b1));
    check_eq("long_configured", 128'(configured), 128'(1'b1));

    // registered feedback toggle on slice 1, enable-gated hold on slice 0
    in = 4'h0;
    ce = 1'b0;
    sr = 1'b0;
    shift_vec(cfg4, 66);
    commit();
    check_eq("tog_commit_err", 128'(cfg_err), 128'(1'b0));
    check_eq("tog_p0", 128'(out), 128'(2'b01));
    tick();
    check_eq("tog_p1", 128'(out), 128'(2'b11));
    tick();
    check_eq("tog_p2", 128'(out), 128'(2'b01));
    ce = 1'b1;
    tick();
    check_eq("tog_p3_ce", 128'(out), 128'(2'b10));
    ce = 1'b0;
    sr = 1'b1;
    tick();
    check_eq("tog_sr1", 128'(out), 128'(2'b00));
    tick();
    check_eq("tog_sr2", 128'(out), 128'(2'b00));
    tick();
    check_eq("tog_sr3", 128'(out), 128'(2'b00));

    // reset mid-shift and mid-toggle
    sr = 1'b0;
    shift_vec({66{1'b1}}, 31);
    check_eq("pre_reset_out", 128'(out), 128'(2'b10));
    check_eq("pre_reset_configured", 128'(configured), 128'(1'b1));
    #1;
    reset = 1'b1;
    #1;
    check_eq("midrst_out", 128'(out), 128'(2'b00));
    check_eq("midrst_configured", 128'(configured), 128'(1'b0));
    check_eq("midrst_cfg_err", 128'(cfg_err), 128'(1'b0));
    check_eq("midrst_cfg_out", 128'(cfg_out), 128'(1'b0));
    reset = 1'b0;
    tick();
    commit();
    check_eq("post_rst_commit_err", 128'(cfg_err), 128'(1'b1));
    check_eq("post_rst_commit_configured", 128'(configured), 128'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
